// File: rtl/wb_dest_queue.sv
// wb_dest_queue: in-order destination queue pairing writeback data with decoded write addresses.
module wb_dest_queue #(
   parameter int AW           = 5,
   parameter int DW           = 32,
   parameter int DEPTH        = 4,
   parameter int LINK_REG     = 31,
   parameter int ZERO_DISCARD = 1
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       cap_valid,
   output logic                       cap_ready,
   input  logic [1:0]                 RegDst,
   input  logic                       RegWrite,
   input  logic [AW-1:0]              rt,
   input  logic [AW-1:0]              rd,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [DW-1:0]              wb_data,
   output logic                       rf_we,
   output logic [AW-1:0]              rf_waddr,
   output logic [DW-1:0]              rf_wdata,
   input  logic [AW-1:0]              q_addr_a,
   input  logic [AW-1:0]              q_addr_b,
   output logic                       q_busy_a,
   output logic                       q_busy_b,
   output logic [$clog2(DEPTH):0]     count,
   output logic [1:0]                 err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic          we_q   [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    err_q, err_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic [AW-1:0] res_addr;
   logic          res_we, full, empty, push, pop;
   logic [PW-1:0] off [DEPTH];

   always_comb begin
      res_addr = RegDst == 2'b00 ? AW'(LINK_REG) :
                 RegDst == 2'b01 ? rt :
                 RegDst == 2'b10 ? rd : '0;
      res_we   = RegDst != 2'b11 && RegWrite && !(ZERO_DISCARD != 0 && res_addr == '0);
      full     = count_q == CW'(DEPTH);
      empty    = count_q == '0;
      pop      = wb_valid && !empty;
      // a full queue still accepts a push when the head leaves in the same cycle
      push     = cap_valid && (!full || pop);
      head_d   = pop  ? head_q + PW'(1) : head_q;
      tail_d   = push ? tail_q + PW'(1) : tail_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      err_d    = err_q | {wb_valid && empty, cap_valid && !push};
      rf_we_d    = pop && we_q[head_q];
      rf_waddr_d = pop ? addr_q[head_q] : rf_waddr_q;
      rf_wdata_d = pop ? wb_data : rf_wdata_q;
   end

   // entry i is live when its distance from the head is below the occupancy
   always_comb begin
      q_busy_a = 1'b0;
      q_busy_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off[i] = PW'(i) - head_q;
         if ({1'b0, off[i]} < count_q && we_q[i]) begin
            q_busy_a = q_busy_a | (addr_q[i] == q_addr_a);
            q_busy_b = q_busy_b | (addr_q[i] == q_addr_b);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         addr_q[tail_q] <= res_addr;
         we_q[tail_q]   <= res_we;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         err_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         err_q      <= err_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign cap_ready = !full;
   assign wb_ready  = !empty;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign count     = count_q;
   assign err       = err_q;
endmodule
